crc_scheduler: RTL and testbench
================================

# crc_scheduler

Shares one bit-serial CRC-5 engine between NREQ requesters. Each requester presents a 4-bit word with a valid/ready handshake. A round-robin arbiter grants one word at a time, shifts it MSB-first through the LFSR, and returns the 5-bit remainder tagged with the requester index. It sits between the data producers and the CRC datapath, replacing per-requester manual reset/load sequencing of the engine.

## Interface
- NREQ, 4: number of requesters, 2..8.
- DW, 4: data word width in bits.
- CW, 5: CRC width in bits.
- POLY, 5'b00101: generator x^5+x^2+1, without the x^5 term.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NREQ  per-requester word valid.
- req_data  in  NREQ*DW  word of requester i at bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot accept strobe.
- rsp_valid  out  1  result available.
- rsp_id  out  $clog2(NREQ)  index of the requester that owns the result.
- rsp_crc  out  CW  CRC remainder.
- rsp_ready  in  1  consumer accepts the result.
- done_count  out  16  completed-job counter; present only with CRC_SCHED_STATS_EN.

## Operation
- **CRC definition:** remainder of data·x^CW mod G. Init 0, MSB-first, no reflection, no final XOR.
- **Per-bit step:** fb = crc[CW-1]^b; crc = {crc[CW-2:0],0} ^ (fb ? POLY : 0).
- **FSM:** IDLE → SHIFT → DONE → IDLE.
- **IDLE:**
  - If any req_valid is high, grant the first valid index at or after rr_ptr, searching upward with wrap.
  - Drive req_ready[grant]=1 combinationally in that cycle.
  - Capture req_data[grant] and the grant id, clear the LFSR, and go to SHIFT.
- **SHIFT:** one bit per cycle from MSB. A bit counter runs 0..DW-1. After the DW-th bit, go to DONE.
- **DONE:**
  - Hold rsp_valid=1 with rsp_id and rsp_crc stable until rsp_ready=1.
  - On the handshake edge, set rr_ptr = grant+1 mod NREQ and go to IDLE.
- **req_ready** is zero in SHIFT and DONE. At most one bit is ever high.
- **Requester rules:**
  - A requester holds req_valid and req_data stable until req_ready.
  - A requester may drop req_valid before it is granted; no job is recorded in that case.
- **Reset values:** state=IDLE, rr_ptr=0, LFSR=0, bit counter=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_crc=0, done_count=0.
- **Reset mid-job:** an assertion in SHIFT or DONE discards the job with no response, and rsp_valid falls on the next edge.
- **rsp_crc outside DONE:** holds the last result.

## Timing
- **Accept:** a request is accepted at edge E0 (IDLE, req_ready high).
- **Result latency:** rsp_valid is first high in the cycle after edge E0+DW, i.e. DW+1 cycles after the req_ready cycle.
- **Minimum job period:** DW+2 cycles (IDLE, DW×SHIFT, DONE with rsp_ready already high).
- **No overlap:** a new grant happens only in IDLE, never in the same cycle as the DONE handshake.
- **Fairness:** with all requesters continuously valid, grants cycle 0,1,…,NREQ-1,0.
- **Starvation bound:** NREQ·(DW+2) cycles plus consumer stalls.

## Configuration
- **CRC_SCHED_STATS_EN defined:**
  - done_count increments by 1 on every DONE handshake and wraps from 16'hFFFF to 0.
  - Cleared by reset.
- **CRC_SCHED_STATS_EN undefined:** the port and the counter are absent. All other behaviour is identical.

## Structure
- **Package crc_sched_pkg:**
  - State enum {IDLE, SHIFT, DONE}.
  - Default POLY and CW constants.
  - Function crc_step(crc, bit) implementing the per-bit step.
- **Sub-module crc_lfsr:**
  - Ports: clk, reset, clr, en, din, crc.
  - The CW-bit register using crc_step.
- **Top level:** crc_scheduler holds the arbiter, FSM, bit counter and response registers.

## Test plan
- **Single request:** requester 1 sends 4'b0111 with rsp_ready=1 → req_ready[1] for one cycle; rsp_valid 5 cycles later with rsp_id=1, rsp_crc=5'b11011.
- **Value sweep:**
  - 4'b0000 → 5'b00000
  - 4'b1001 → 5'b01000
  - 4'b0010 → 5'b01010
  - All 16 words are checked against the bench model.
- **Round-robin:** all 4 requesters continuously valid → grant order 0,1,2,3,0. Back-to-back job spacing is 6 cycles.
- **Backpressure:** rsp_ready low for 10 cycles in DONE → rsp_valid, rsp_id and rsp_crc held stable, all req_ready=0; the result completes the cycle rsp_ready rises.
- **Reset mid-SHIFT:** assert reset for 1 cycle in bit 2 → no response; rr_ptr=0; the next request from requester 3 returns the correct CRC.
- **Stats (CRC_SCHED_STATS_EN):** 5 completed jobs → done_count=5. Preload near 16'hFFFF and complete 2 jobs → done_count wraps to 0 and then 1.

Source files
------------

// File: rtl/crc_sched_pkg.sv
// Shared definitions for the CRC-5 scheduler: FSM state type, default
// polynomial/width, and the single-bit LFSR step.
package crc_sched_pkg;

  localparam int              CRC_W    = 5;
  localparam logic [CRC_W-1:0] CRC_POLY = 5'b00101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // MSB-first step; poly omits the implicit x^CRC_W term.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                input logic             din,
                                                input logic [CRC_W-1:0] poly);
    logic fb;
    fb = crc[CRC_W-1] ^ din;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
  endfunction

endpackage

// File: rtl/crc_lfsr.sv
// Bit-serial CRC register: clear has priority over enable, one bit per
// enabled cycle.
module crc_lfsr
  import crc_sched_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC_POLY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= '0;
    end else if (clr) begin
      crc_q <= '0;
    end else if (en) begin
      crc_q <= crc_step(crc_q, din, POLY);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/crc_scheduler.sv
// Round-robin sharing of one bit-serial CRC-5 engine between NREQ requesters.
// Optional completed-job counter enabled by defining CRC_SCHED_STATS_EN.
module crc_scheduler
  import crc_sched_pkg::*;
#(
  parameter int               NREQ = 4,
  parameter int               DW   = 4,
  parameter int               CW   = CRC_W,
  parameter logic [CRC_W-1:0] POLY = CRC_POLY,
  localparam int              IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [CW-1:0]      rsp_crc,
  input  logic               rsp_ready
`ifdef CRC_SCHED_STATS_EN
  ,
  output logic [15:0]        done_count
`endif
);

  localparam int CNTW = (DW > 1) ? $clog2(DW) : 1;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [DW-1:0]   data_q, data_d;
  logic [CNTW-1:0] bitcnt_q, bitcnt_d;
  logic [CW-1:0]   rsp_crc_q, rsp_crc_d;

  logic            any_valid;
  logic [IDW-1:0]  sel;
  logic            lfsr_clr, lfsr_en;
  logic [CW-1:0]   lfsr_crc;

  // Walk downward so the lowest offset from rr_ptr is the one left in sel.
  always_comb begin
    any_valid = 1'b0;
    sel       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[IDW'(idx)]) begin
        any_valid = 1'b1;
        sel       = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    data_d    = data_q;
    bitcnt_d  = bitcnt_q;
    rsp_crc_d = rsp_crc_q;
    req_ready = '0;
    lfsr_clr  = 1'b0;
    lfsr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid && !reset) begin
          req_ready[sel] = 1'b1;
          grant_d        = sel;
          data_d         = req_data[int'(sel)*DW +: DW];
          bitcnt_d       = '0;
          lfsr_clr       = 1'b1;
          state_d        = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        lfsr_en = 1'b1;
        data_d  = {data_q[DW-2:0], 1'b0};
        if (bitcnt_q == CNTW'(DW - 1)) begin
          bitcnt_d = '0;
          state_d  = ST_DONE;
        end else begin
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          rr_ptr_d  = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
          rsp_crc_d = lfsr_crc;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      data_q    <= '0;
      bitcnt_q  <= '0;
      rsp_crc_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      bitcnt_q  <= bitcnt_d;
      rsp_crc_q <= rsp_crc_d;
    end
  end

  crc_lfsr #(
    .POLY (POLY)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .clr   (lfsr_clr),
    .en    (lfsr_en),
    .din   (data_q[DW-1]),
    .crc   (lfsr_crc)
  );

  // The LFSR is cleared by the next grant, so the last result is kept aside.
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_id    = grant_q;
  assign rsp_crc   = rsp_valid ? lfsr_crc : rsp_crc_q;

`ifdef CRC_SCHED_STATS_EN
  logic [15:0] done_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      done_count_q <= '0;
    end else if (state_q == ST_DONE && rsp_ready) begin
      done_count_q <= done_count_q + 16'd1;
    end
  end

  assign done_count = done_count_q;
`endif

endmodule

// File: tb/tb_crc_scheduler.sv
// Directed + randomized bench for crc_scheduler against a polynomial-division
// CRC model and a round-robin grant model.
module tb_crc_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 4;
  localparam int CW   = 5;
  localparam logic [8:0] GEN = 9'b000100101;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [CW-1:0]     rsp_crc;
  logic              rsp_ready;
`ifdef CRC_SCHED_STATS_EN
  logic [15:0]       done_count;
`endif

  crc_scheduler #(.NREQ(NREQ), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_crc   (rsp_crc),
    .rsp_ready (rsp_ready)
`ifdef CRC_SCHED_STATS_EN
    ,
    .done_count(done_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ptr_m = 0;
  logic [15:0] jobs_m = '0;
  logic [NREQ-1:0] vld;
  logic [DW-1:0]   dat [NREQ];
  logic [CW-1:0]   last_crc;
  int              last_id;

  // Remainder of w * x^5 by long division over GF(2).
  function automatic logic [CW-1:0] crc_ref(input logic [DW-1:0] w);
    logic [8:0] v;
    v = {w, 5'b00000};
    for (int i = 8; i >= 5; i--)
      if (v[i]) v = v ^ (GEN << (i - 5));
    return v[4:0];
  endfunction

  function automatic int exp_grant(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply();
    req_valid = vld;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = dat[i];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rsp_ready = 1'b0;
    vld = '1;
    apply();
    #1;
    chk("ready_in_reset", 32'(req_ready), 32'd0);
    tick();
    tick();
    vld = '0;
    apply();
    reset = 1'b0;
    ptr_m = 0;
    jobs_m = '0;
  endtask

  // One complete job from grant through the DONE handshake.
  task automatic run_job(input int stall, input bit keep, output int t_acc);
    int g, lat;
    logic [DW-1:0] w;
    logic [1:0] hid;
    logic [CW-1:0] hcrc;
    bit stable, quiet;
    apply();
    #1;
    g = exp_grant(vld, ptr_m);
    chk("grant", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    t_acc = cyc;
    if (g < 0) return;
    w = dat[g];
    rsp_ready = (stall == 0);
    tick();
    if (keep) dat[g] = DW'($urandom);
    else      vld[g] = 1'b0;
    apply();
    lat = 1;
    quiet = 1'b1;
    while (!rsp_valid && lat < 20) begin
      if (req_ready !== '0) quiet = 1'b0;
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'(DW + 1));
    chk("ready_low_shift", 32'(quiet), 32'd1);
    if (stall > 0) begin
      hid = rsp_id;
      hcrc = rsp_crc;
      stable = 1'b1;
      repeat (stall) begin
        tick();
        if (!rsp_valid || rsp_id !== hid || rsp_crc !== hcrc || req_ready !== '0) stable = 1'b0;
      end
      chk("hold_stable", 32'(stable), 32'd1);
      rsp_ready = 1'b1;
    end
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("rsp_crc", 32'(rsp_crc), 32'(crc_ref(w)));
    last_crc = rsp_crc;
    last_id = int'(rsp_id);
    tick();
    ptr_m = (g + 1) % NREQ;
    jobs_m = jobs_m + 16'd1;
    chk("valid_after_hs", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int t0, t1;
    bit quiet;
    reset = 1'b1;
    rsp_ready = 1'b0;
    vld = '0;
    for (int i = 0; i < NREQ; i++) dat[i] = '0;
    apply();
    @(negedge clk);

    do_reset();
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_crc", 32'(rsp_crc), 32'd0);
`ifdef CRC_SCHED_STATS_EN
    chk("rst_count", 32'(done_count), 32'd0);
`endif

    // Single request from requester 1.
    vld = 4'b0010;
    dat[1] = 4'b0111;
    run_job(0, 1'b0, t0);
    chk("crc_0111", 32'(last_crc), 32'h1B);
    chk("crc_hold_idle", 32'(rsp_crc), 32'h1B);

    // Directed values, then full sweep on random requesters.
    vld = 4'b0001; dat[0] = 4'b0000; run_job(0, 1'b0, t0);
    chk("crc_0000", 32'(last_crc), 32'h00);
    vld = 4'b0100; dat[2] = 4'b1001; run_job(1, 1'b0, t0);
    chk("crc_1001", 32'(last_crc), 32'h08);
    vld = 4'b1000; dat[3] = 4'b0010; run_job(0, 1'b0, t0);
    chk("crc_0010", 32'(last_crc), 32'h0A);
    for (int w = 0; w < 16; w++) begin
      int id;
      id = int'($urandom_range(0, NREQ - 1));
      vld = '0;
      vld[id] = 1'b1;
      dat[id] = DW'(w);
      run_job(int'($urandom_range(0, 2)), 1'b0, t0);
    end

    // Round robin with all requesters continuously valid.
    do_reset();
    vld = '1;
    for (int i = 0; i < NREQ; i++) dat[i] = DW'($urandom);
    run_job(0, 1'b1, t0);
    chk("rr_order", 32'(last_id), 32'd0);
    for (int k = 1; k <= NREQ; k++) begin
      run_job(0, 1'b1, t1);
      chk("rr_order", 32'(last_id), 32'(k % NREQ));
      chk("rr_spacing", 32'(t1 - t0), 32'(DW + 2));
      t0 = t1;
    end
    vld = '0;
    apply();

    // Backpressure for 10 cycles.
    vld = 4'b0100; dat[2] = DW'($urandom);
    run_job(10, 1'b0, t0);

    // Reset during bit 2 of a job from requester 2, with rr_ptr previously 2.
    vld = 4'b0010; dat[1] = DW'($urandom);
    run_job(0, 1'b0, t0);
    vld = 4'b0100; dat[2] = DW'($urandom);
    apply();
    #1;
    chk("grant_pre_rst", 32'(req_ready), 32'b0100);
    rsp_ready = 1'b1;
    tick();
    vld = '0;
    apply();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ptr_m = 0;
    jobs_m = '0;
    chk("rst_mid_crc", 32'(rsp_crc), 32'd0);
    quiet = 1'b1;
    repeat (8) begin
      if (rsp_valid !== 1'b0) quiet = 1'b0;
      tick();
    end
    chk("no_rsp_after_rst", 32'(quiet), 32'd1);
    vld = 4'b1010; dat[1] = DW'($urandom); dat[3] = DW'($urandom);
    run_job(0, 1'b0, t0);
    chk("ptr_reset_grant", 32'(last_id), 32'd1);
    run_job(0, 1'b0, t0);
    chk("req3_after_rst", 32'(last_id), 32'd3);

    // Randomized mix of masks, stalls and requester behaviour.
    for (int n = 0; n < 24; n++) begin
      if (vld == '0 || $urandom_range(0, 2) == 0) vld = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 1) == 1) dat[i] = DW'($urandom);
      run_job(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), t0);
    end
    vld = '0;
    apply();

`ifdef CRC_SCHED_STATS_EN
    chk("count_mix", 32'(done_count), 32'(jobs_m));
    do_reset();
    for (int n = 0; n < 5; n++) begin
      vld = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      run_job(0, 1'b0, t0);
    end
    chk("count_5", 32'(done_count), 32'd5);
    vld = '0;
    apply();
    force dut.done_count_q = 16'hFFFF;
    #1;
    release dut.done_count_q;
    jobs_m = 16'hFFFF;
    vld = 4'b0001; run_job(0, 1'b0, t0);
    chk("count_wrap0", 32'(done_count), 32'(jobs_m));
    chk("count_wrap0_abs", 32'(done_count), 32'd0);
    vld = 4'b0010; run_job(0, 1'b0, t0);
    chk("count_wrap1", 32'(done_count), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
